// File: rtl/product_accumulator.sv
// Frame accumulator: sums a stream of unsigned products until the beat carrying input_last,
// then holds sum, beat count and carry flag on a valid/ready output until it is accepted.
module product_accumulator #(
    parameter int unsigned IN_WIDTH    = 16,
    parameter int unsigned ACC_WIDTH   = 24,
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [IN_WIDTH-1:0]    input_data,
    input  logic                   input_last,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [ACC_WIDTH-1:0]   sum,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   overflow
);

    typedef enum logic [0:0] {
        StAccum,
        StHold
    } state_e;

    state_e                 r_state;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [COUNT_WIDTH-1:0] r_cnt;
    logic                   r_ovf;
    logic                   r_in_ready;
    logic                   r_out_valid;

    logic [ACC_WIDTH:0]     w_add;
    logic                   w_in_hs;
    logic                   w_out_hs;
    logic [COUNT_WIDTH-1:0] w_cnt_next;

    // One extra bit on the adder captures the carry out of the accumulator.
    assign w_add = {1'b0, r_acc} + {{(ACC_WIDTH + 1 - IN_WIDTH){1'b0}}, input_data};

    assign w_in_hs    = input_valid & r_in_ready;
    assign w_out_hs   = r_out_valid & output_ready;
    assign w_cnt_next = (r_cnt == {COUNT_WIDTH{1'b1}})
                      ? r_cnt
                      : r_cnt + {{(COUNT_WIDTH - 1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StAccum;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                StAccum: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    if (w_in_hs) begin
                        r_acc <= w_add[ACC_WIDTH-1:0];
                        r_ovf <= r_ovf | w_add[ACC_WIDTH];
                        r_cnt <= w_cnt_next;
                        if (input_last) begin
                            r_state     <= StHold;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                StHold: begin
                    if (w_out_hs) begin
                        r_state     <= StAccum;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_ovf       <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= StAccum;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign input_ready  = r_in_ready;
    assign output_valid = r_out_valid;
    assign sum          = r_acc;
    assign count        = r_cnt;
    assign overflow     = r_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: directed frames with literal expectations plus a randomised
// stream checked every cycle against a frame-level arithmetic model.
module tb_product_accumulator;

    localparam int unsigned IW = 16;
    localparam int unsigned AW = 24;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          input_valid = 1'b0;
    logic          input_ready;
    logic [IW-1:0] input_data = '0;
    logic          input_last = 1'b0;
    logic          output_valid;
    logic          output_ready = 1'b0;
    logic [AW-1:0] sum;
    logic [CW-1:0] count;
    logic          overflow;

    product_accumulator #(
        .IN_WIDTH   (IW),
        .ACC_WIDTH  (AW),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .input_valid (input_valid),
        .input_ready (input_ready),
        .input_data  (input_data),
        .input_last  (input_last),
        .output_valid(output_valid),
        .output_ready(output_ready),
        .sum         (sum),
        .count       (count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Frame-level model: a running total of accepted beats, nothing about the RTL's registers.
    longint m_total   = 0;
    int     m_n       = 0;
    bit     m_hold    = 0;
    bit     m_ready   = 0;
    bit     m_rst     = 1;
    bit     started   = 0;
    int     hs_out    = 0;
    int     frames_tx = 0;
    bit     rand_rdy  = 0;

    function automatic longint exp_sum();
        return m_total % (64'd1 << AW);
    endfunction
    function automatic longint exp_cnt();
        return (m_n > 255) ? 255 : m_n;
    endfunction
    function automatic longint exp_ovf();
        return (m_total >= (64'd1 << AW)) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        started = 1;
        if (!reset && output_valid && output_ready) hs_out++;
        m_rst = reset;
        if (reset) begin
            m_total = 0; m_n = 0; m_hold = 0; m_ready = 0;
        end else if (m_hold) begin
            if (output_ready) begin
                m_hold = 0; m_total = 0; m_n = 0;
            end
            m_ready = !m_hold;
        end else begin
            if (input_valid && m_ready) begin
                m_total += longint'(input_data);
                m_n++;
                if (input_last) m_hold = 1;
            end
            m_ready = !m_hold;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            if (m_rst) begin
                chk("rst_output_valid", output_valid, 0);
                chk("rst_input_ready", input_ready, 0);
                chk("rst_sum", sum, 0);
                chk("rst_count", count, 0);
                chk("rst_overflow", overflow, 0);
            end else begin
                chk("output_valid", output_valid, m_hold);
                chk("input_ready", input_ready, m_ready);
                if (m_hold) begin
                    chk("sum", sum, exp_sum());
                    chk("count", count, exp_cnt());
                    chk("overflow", overflow, exp_ovf());
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            output_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic garbage_inputs();
        logic [31:0] r;
        r = $urandom;
        input_data = r[15:0];
        input_last = r[16];
    endtask

    // Called #1 after an edge; returns #1 after the edge on which the beat was taken.
    task automatic send_beat(input logic [IW-1:0] d, input logic l, input int idle);
        bit ok;
        repeat (idle) begin
            @(posedge clk);
            #1;
        end
        input_valid = 1'b1;
        input_data  = d;
        input_last  = l;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (input_ready) begin
                ok = 1;
                break;
            end
        end
        #1;
        input_valid = 1'b0;
        garbage_inputs();
        if (!ok) chk("beat_accept_timeout", 0, 1);
        else if (l) frames_tx++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] r;
        int nb;
        int hs0;
        bit ok;

        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("ready_after_release", input_ready, 1);

        // Frame 578 + 65025 + 1 with an always-ready consumer.
        output_ready = 1'b1;
        send_beat(16'd578, 1'b0, 0);
        send_beat(16'd65025, 1'b0, 0);
        send_beat(16'd1, 1'b1, 0);
        chk("f1_valid", output_valid, 1);
        chk("f1_sum", sum, 65604);
        chk("f1_count", count, 3);
        chk("f1_ovf", overflow, 0);
        chk("f1_model_sum", exp_sum(), 65604);
        tick(1);
        chk("f1_ready_back", input_ready, 1);

        // Same frame, consumer stalled for 10 cycles.
        output_ready = 1'b0;
        send_beat(16'd578, 1'b0, 0);
        send_beat(16'd65025, 1'b0, 0);
        send_beat(16'd1, 1'b1, 0);
        hs0 = hs_out;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", output_valid, 1);
            chk("bp_sum", sum, 65604);
            chk("bp_ready", input_ready, 0);
            tick(1);
        end
        output_ready = 1'b1;
        tick(1);
        output_ready = 1'b0;
        chk("bp_valid_drop", output_valid, 0);
        chk("bp_ready_back", input_ready, 1);
        tick(2);
        chk("bp_one_handshake", hs_out - hs0, 1);

        // 300 beats of 65025: wraps the 24-bit sum, saturates the count.
        for (int i = 1; i <= 300; i++) send_beat(16'd65025, (i == 300), 0);
        chk("ov_sum", sum, 2730284);
        chk("ov_count", count, 255);
        chk("ov_flag", overflow, 1);
        chk("ov_model_sum", exp_sum(), 2730284);
        chk("ov_model_flag", exp_ovf(), 1);
        output_ready = 1'b1;
        tick(1);
        output_ready = 1'b0;
        send_beat(16'd5, 1'b1, 0);
        chk("single_sum", sum, 5);
        chk("single_count", count, 1);
        chk("single_ovf_cleared", overflow, 0);
        output_ready = 1'b1;
        tick(1);
        output_ready = 1'b0;

        // Reset after 2 of 4 beats, then a clean 5 + 7 frame.
        send_beat(16'd100, 1'b0, 0);
        send_beat(16'd200, 1'b0, 0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        send_beat(16'd5, 1'b0, 0);
        send_beat(16'd7, 1'b1, 0);
        chk("mid_rst_sum", sum, 12);
        chk("mid_rst_count", count, 2);
        chk("mid_rst_ovf", overflow, 0);
        output_ready = 1'b1;
        tick(1);

        // Randomised frames of 8x8 products with stalls on both sides.
        rand_rdy = 1;
        for (int f = 0; f < 1000; f++) begin
            nb = $urandom_range(1, 8);
            for (int b = 1; b <= nb; b++) begin
                r = $urandom;
                send_beat(16'(r[7:0]) * 16'(r[15:8]), (b == nb), $urandom_range(0, 2));
            end
        end
        rand_rdy = 0;
        tick(2);
        output_ready = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (!m_hold) begin
                ok = 1;
                break;
            end
        end
        chk("drain_done", ok, 1);
        tick(2);
        chk("handshakes_per_frame", hs_out, frames_tx);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
